// File: rtl/i2c_pkg.sv
// I2C bit sequencer shared package: command and phase encodings,
// default prescale and the per-phase line table.
package i2c_pkg;

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_STOP  = 2'd1,
        CMD_WRITE = 2'd2,
        CMD_READ  = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PH0,
        ST_PH1,
        ST_PH2,
        ST_PH3
    } state_e;

    // 100 kHz SCL from a 50 MHz clock: 4 * 125 cycles per bit.
    localparam int unsigned PRESC_100K = 124;

    function automatic logic [1:0] phase_lines(
        input cmd_e   cmd,
        input logic   b,
        input state_e st
    );
        logic [1:0] r;
        logic       scl_lo;
        scl_lo = (st == ST_PH0) || (st == ST_PH3);
        r = 2'b00;
        unique case (cmd)
            CMD_START: begin
                unique case (st)
                    ST_PH2:  r = 2'b01;
                    ST_PH3:  r = 2'b11;
                    default: r = 2'b00;
                endcase
            end
            CMD_STOP: begin
                unique case (st)
                    ST_PH0:  r = 2'b11;
                    ST_PH1:  r = 2'b01;
                    ST_PH2:  r = 2'b01;
                    default: r = 2'b00;
                endcase
            end
            CMD_WRITE: r = {scl_lo, ~b};
            CMD_READ:  r = {scl_lo, 1'b0};
            default:   r = 2'b00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/i2c_sync.sv
// Multi-stage synchroniser for an I2C pad sense line.
// Resets to 1, the idle level of a pulled-up bus.
module i2c_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '1;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/i2c_bit_sequencer.sv
// I2C bit sequencer: START/STOP/WRITE/READ as four quarter-phases.
// Define I2C_CLK_STRETCH_EN to hold PH1 while a slave stretches SCL.
module i2c_bit_sequencer
    import i2c_pkg::*;
#(
    parameter int PRESC_W     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               Enable,
    input  logic [PRESC_W-1:0] Prescale,
    input  logic               Cmd_valid,
    output logic               Cmd_ready,
    input  logic [1:0]         Cmd,
    input  logic               Cmd_bit,
    input  logic               Scl_in,
    input  logic               Sda_in,
    output logic               Scl_oe,
    output logic               Sda_oe,
    output logic               Rsp_valid,
    output logic               Rsp_bit,
    output logic               Arb_lost,
    output logic               Busy
);

    state_e             state;
    cmd_e               cmd_q;
    logic               bit_q;
    logic [PRESC_W-1:0] cnt;
    logic [PRESC_W-1:0] presc_q;
    logic               sda_smp;
    logic               idle_q;
    logic               scl_s;
    logic               sda_s;
    logic               hold;
    logic               rsp_cmd;

    i2c_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
        .clk   (Clk),
        .rst_n (Rst_n),
        .d     (Scl_in),
        .q     (scl_s)
    );

    i2c_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
        .clk   (Clk),
        .rst_n (Rst_n),
        .d     (Sda_in),
        .q     (sda_s)
    );

`ifdef I2C_CLK_STRETCH_EN
    assign hold = (state == ST_PH1) && !scl_s;
`else
    // SCL sense is kept on the port but never stalls timing.
    assign hold = 1'b0 & scl_s;
`endif

    assign rsp_cmd   = (cmd_q == CMD_WRITE) || (cmd_q == CMD_READ);
    assign Cmd_ready = idle_q & Enable;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= ST_IDLE;
            cmd_q     <= CMD_START;
            bit_q     <= 1'b0;
            cnt       <= '0;
            presc_q   <= '0;
            sda_smp   <= 1'b0;
            idle_q    <= 1'b0;
            Scl_oe    <= 1'b0;
            Sda_oe    <= 1'b0;
            Rsp_valid <= 1'b0;
            Rsp_bit   <= 1'b0;
            Arb_lost  <= 1'b0;
            Busy      <= 1'b0;
        end else begin
            Rsp_valid <= 1'b0;
            Arb_lost  <= 1'b0;
            if (state != ST_IDLE && !Enable) begin
                state  <= ST_IDLE;
                cnt    <= '0;
                idle_q <= 1'b1;
                Busy   <= 1'b0;
                Scl_oe <= 1'b0;
                Sda_oe <= 1'b0;
            end else if (state == ST_IDLE) begin
                idle_q <= 1'b1;
                if (Cmd_valid && Cmd_ready) begin
                    state   <= ST_PH0;
                    cmd_q   <= cmd_e'(Cmd);
                    bit_q   <= Cmd_bit;
                    presc_q <= Prescale;
                    cnt     <= Prescale;
                    idle_q  <= 1'b0;
                    Busy    <= 1'b1;
                    {Scl_oe, Sda_oe} <=
                        phase_lines(cmd_e'(Cmd), Cmd_bit, ST_PH0);
                end
            end else if (hold) begin
                cnt <= cnt;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
                if (state == ST_PH3 && cnt == PRESC_W'(1) && rsp_cmd) begin
                    Rsp_valid <= 1'b1;
                    Rsp_bit   <= sda_smp;
                end
            end else begin
                cnt <= presc_q;
                unique case (state)
                    ST_PH0: begin
                        state <= ST_PH1;
                        {Scl_oe, Sda_oe} <= phase_lines(cmd_q, bit_q, ST_PH1);
                    end
                    ST_PH1: begin
                        state <= ST_PH2;
                        {Scl_oe, Sda_oe} <= phase_lines(cmd_q, bit_q, ST_PH2);
                    end
                    ST_PH2: begin
                        sda_smp <= sda_s;
                        if (cmd_q == CMD_WRITE && bit_q && !sda_s) begin
                            state    <= ST_IDLE;
                            idle_q   <= 1'b1;
                            Busy     <= 1'b0;
                            Arb_lost <= 1'b1;
                            Scl_oe   <= 1'b0;
                            Sda_oe   <= 1'b0;
                        end else begin
                            state <= ST_PH3;
                            {Scl_oe, Sda_oe} <=
                                phase_lines(cmd_q, bit_q, ST_PH3);
                            if (presc_q == '0 && rsp_cmd) begin
                                Rsp_valid <= 1'b1;
                                Rsp_bit   <= sda_s;
                            end
                        end
                    end
                    ST_PH3: begin
                        // Lines keep their PH3 levels so SCL stays owned.
                        state  <= ST_IDLE;
                        idle_q <= 1'b1;
                        Busy   <= 1'b0;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
